// File: rtl/ext_bus_ctrl_if.sv
// ext_bus_ctrl_if
// Bundles the cpu-side request/response signals and the external
// multiplexed-bus pins handled by ext_bus_ctrl.
//   cpu side : address, read, write, dataIn, byteCount  -> controller
//              dataOut, dataOutReady, dataInReady, busy  <- controller
//   bus side : ioIn (pin value)                          -> controller
//              ioOut, ioOe, addressLatch0/1, RAM CE/RD/WR,
//              ROM CE/RD                                 <- controller
// Modports: master = cpu plus board (drives requests and ioIn),
//           slave  = the controller.
// Handshake: read/write is a level request held by the cpu until the
// matching one-cycle ready pulse (dataOutReady for reads, dataInReady
// for writes); if it is still high in the cycle after the pulse, a new
// transaction starts.
interface ext_bus_ctrl_if;
  logic [23:0] address;
  logic        read;
  logic        write;
  logic [31:0] dataIn;
  logic [1:0]  byteCount;
  logic [31:0] dataOut;
  logic        dataOutReady;
  logic        dataInReady;
  logic        busy;
  logic [7:0]  ioOut;
  logic [7:0]  ioIn;
  logic        ioOe;
  logic        addressLatch0;
  logic        addressLatch1;
  logic        ramChipEnable;
  logic        ramRead;
  logic        ramWrite;
  logic        romChipEnable;
  logic        romRead;

  modport master (
    output address, read, write, dataIn, byteCount, ioIn,
    input  dataOut, dataOutReady, dataInReady, busy, ioOut, ioOe,
           addressLatch0, addressLatch1, ramChipEnable, ramRead, ramWrite,
           romChipEnable, romRead
  );

  modport slave (
    input  address, read, write, dataIn, byteCount, ioIn,
    output dataOut, dataOutReady, dataInReady, busy, ioOut, ioOe,
           addressLatch0, addressLatch1, ramChipEnable, ramRead, ramWrite,
           romChipEnable, romRead
  );
endinterface

// File: rtl/ext_bus_ctrl.sv
// ext_bus_ctrl
// Expands each cpu request (1-4 bytes) into byte-wide cycles on the
// board's 8-bit multiplexed bus: LATCH_LO, LATCH_HI, ACCESS (W cycles),
// RECOVER, and finally a DONE cycle that produces the ready pulse.
// Target is RAM when address[15] is set, ROM otherwise; it is fixed for
// the whole transaction even when the byte address wraps past 0xFFFF.
// ROM writes perform no bus cycles and are acknowledged immediately.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : ext_bus_ctrl_if.slave (cpu request side and bus pins)
//   dbg_state  : current FSM state, for observation only
// Parameters: RAM_WAIT / ROM_WAIT = ACCESS length per byte (1..15).
// Optional macro BUS_HILATCH_CACHE_EN: remembers the last high address
// byte latched on the bus and skips LATCH_HI while it still matches.
//
// Every output is a register decoded from the state of the previous
// cycle, so pins lag the state register by exactly one clock. ioIn is
// therefore sampled while the state is RECOVER: that is the last cycle
// in which the RD strobe is visible on the pins.
module ext_bus_ctrl #(
  parameter int unsigned RAM_WAIT = 2,
  parameter int unsigned ROM_WAIT = 3
) (
  input  logic               clk,
  input  logic               rst,
  ext_bus_ctrl_if.slave      bus,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LATCH_LO = 3'd1,
    LATCH_HI = 3'd2,
    ACCESS   = 3'd3,
    RECOVER  = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [3:0] RAM_W = 4'(RAM_WAIT);
  localparam logic [3:0] ROM_W = 4'(ROM_WAIT);

  state_t      state;
  logic [15:0] base_addr;
  logic [31:0] wdata;
  logic [1:0]  bcnt;
  logic [1:0]  idx;
  logic        is_write;
  logic        is_ram;
  logic [3:0]  wait_cnt;

`ifdef BUS_HILATCH_CACHE_EN
  logic [7:0]  hi_cache;
  logic        hi_valid;
`endif

  logic [15:0] cur_addr;
  logic [7:0]  cur_wbyte;
  logic [3:0]  wait_len;

  // 16-bit add wraps 0xFFFF -> 0x0000 naturally.
  assign cur_addr  = base_addr + {14'd0, idx};
  assign cur_wbyte = wdata[{idx, 3'b000} +: 8];
  assign wait_len  = is_ram ? RAM_W : ROM_W;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      base_addr         <= '0;
      wdata             <= '0;
      bcnt              <= '0;
      idx               <= '0;
      is_write          <= 1'b0;
      is_ram            <= 1'b0;
      wait_cnt          <= '0;
      bus.dataOut       <= '0;
      bus.dataOutReady  <= 1'b0;
      bus.dataInReady   <= 1'b0;
      bus.busy          <= 1'b0;
      bus.ioOut         <= '0;
      bus.ioOe          <= 1'b0;
      bus.addressLatch0 <= 1'b0;
      bus.addressLatch1 <= 1'b0;
      bus.ramChipEnable <= 1'b0;
      bus.ramRead       <= 1'b0;
      bus.ramWrite      <= 1'b0;
      bus.romChipEnable <= 1'b0;
      bus.romRead       <= 1'b0;
`ifdef BUS_HILATCH_CACHE_EN
      hi_cache          <= '0;
      hi_valid          <= 1'b0;
`endif
    end else begin
      // Output defaults: everything idle unless the current state asks.
      bus.dataOutReady  <= 1'b0;
      bus.dataInReady   <= 1'b0;
      bus.busy          <= (state != IDLE);
      bus.ioOut         <= '0;
      bus.ioOe          <= 1'b0;
      bus.addressLatch0 <= 1'b0;
      bus.addressLatch1 <= 1'b0;
      bus.ramChipEnable <= 1'b0;
      bus.ramRead       <= 1'b0;
      bus.ramWrite      <= 1'b0;
      bus.romChipEnable <= 1'b0;
      bus.romRead       <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.read || bus.write) begin
            base_addr <= bus.address[15:0];
            wdata     <= bus.dataIn;
            bcnt      <= bus.byteCount;
            is_write  <= bus.write;
            is_ram    <= bus.address[15];
            idx       <= '0;
            // ROM cannot be written: acknowledge without touching the bus.
            if (bus.write && !bus.address[15]) state <= DONE;
            else                               state <= LATCH_LO;
          end
        end

        LATCH_LO: begin
          bus.ioOe          <= 1'b1;
          bus.ioOut         <= cur_addr[7:0];
          bus.addressLatch0 <= 1'b1;
`ifdef BUS_HILATCH_CACHE_EN
          if (hi_valid && (hi_cache == cur_addr[15:8])) begin
            state    <= ACCESS;
            wait_cnt <= wait_len - 4'd1;
          end else begin
            state    <= LATCH_HI;
          end
`else
          state <= LATCH_HI;
`endif
        end

        LATCH_HI: begin
          bus.ioOe          <= 1'b1;
          bus.ioOut         <= cur_addr[15:8];
          bus.addressLatch1 <= 1'b1;
`ifdef BUS_HILATCH_CACHE_EN
          hi_cache <= cur_addr[15:8];
          hi_valid <= 1'b1;
`endif
          state    <= ACCESS;
          wait_cnt <= wait_len - 4'd1;
        end

        ACCESS: begin
          bus.ramChipEnable <= is_ram;
          bus.romChipEnable <= !is_ram;
          if (is_write) begin
            bus.ramWrite <= 1'b1;
            bus.ioOe     <= 1'b1;
            bus.ioOut    <= cur_wbyte;
          end else begin
            bus.ramRead  <= is_ram;
            bus.romRead  <= !is_ram;
          end
          if (wait_cnt == 4'd0) state <= RECOVER;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end

        RECOVER: begin
          bus.ramChipEnable <= is_ram;
          bus.romChipEnable <= !is_ram;
          if (is_write) begin
            // Keep data on the pins one cycle past WR for hold time.
            bus.ioOe  <= 1'b1;
            bus.ioOut <= cur_wbyte;
          end else begin
            bus.dataOut[{idx, 3'b000} +: 8] <= bus.ioIn;
          end
          if (idx == bcnt) begin
            state <= DONE;
          end else begin
            idx   <= idx + 2'd1;
            state <= LATCH_LO;
          end
        end

        DONE: begin
          if (is_write) bus.dataInReady  <= 1'b1;
          else          bus.dataOutReady <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// tb_ext_bus_ctrl
// Bench for ext_bus_ctrl: models the two external address latches plus
// RAM/ROM arrays answering RD strobes, monitors strobe widths, bus
// writes and pin-level invariants, and checks transactions against a
// scoreboard of expected read words and expected bus writes.
module tb_ext_bus_ctrl;
  localparam int RAM_W = 2;
  localparam int ROM_W = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ext_bus_ctrl_if bus();
  logic [2:0] dbg_state;

  ext_bus_ctrl #(.RAM_WAIT(RAM_W), .ROM_WAIT(ROM_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  // ---------------- board model ----------------
  logic [7:0]  ram_mem [65536];
  logic [7:0]  rom_mem [65536];
  logic [7:0]  lat_lo = 8'h00;
  logic [7:0]  lat_hi = 8'h00;
  logic [15:0] bus_addr;

  always @(posedge clk) begin
    if (bus.addressLatch0) lat_lo <= bus.ioOut;
    if (bus.addressLatch1) lat_hi <= bus.ioOut;
  end
  assign bus_addr = {lat_hi, lat_lo};

  always_comb begin
    bus.ioIn = 8'h00;
    if (bus.ramRead)      bus.ioIn = ram_mem[bus_addr];
    else if (bus.romRead) bus.ioIn = rom_mem[bus_addr];
  end

  // ---------------- monitor ----------------
  int viol = 0, ram_seen = 0, act_seen = 0, rdy_seen = 0, run_len = 0;
  logic prev_strobe = 1'b0;
  logic [23:0] wr_obs_q[$];
  int          run_q[$];

  always @(negedge clk) begin
    logic s;
    s = bus.ramRead | bus.ramWrite | bus.romRead;
    if (bus.ramChipEnable && bus.romChipEnable) viol++;
    if (bus.ioOe && (bus.ramRead || bus.romRead)) viol++;
    if (bus.ramChipEnable | bus.ramRead | bus.ramWrite) ram_seen++;
    if (s | bus.ioOe | bus.addressLatch0 | bus.addressLatch1 |
        bus.ramChipEnable | bus.romChipEnable) act_seen++;
    if (bus.dataOutReady | bus.dataInReady) rdy_seen++;
    if (bus.ramWrite && !prev_strobe) wr_obs_q.push_back({bus_addr, bus.ioOut});
    if (s) run_len++;
    else if (prev_strobe) begin
      run_q.push_back(run_len);
      run_len = 0;
    end
    prev_strobe = s;
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [23:0] exp_wr_q[$];
  logic [31:0] model_dout = 32'h0;
  int n_cmp = 0, n_bad = 0;

  function automatic logic [31:0] model_read(input logic [15:0] a,
                                             input logic [1:0] bc,
                                             input logic [31:0] prev);
    logic [31:0] r;
    logic [15:0] b;
    r = prev;
    for (int i = 0; i <= int'(bc); i++) begin
      b = a + 16'(i);
      r[8*i +: 8] = a[15] ? ram_mem[b] : rom_mem[b];
    end
    return r;
  endfunction

  function automatic int exp_lat(input logic [15:0] a, input logic [1:0] bc);
    return (int'(bc) + 1) * (3 + (a[15] ? RAM_W : ROM_W)) + 1;
  endfunction

  // ---------------- driver ----------------
  // Call at a negedge. lat = cycles from capture edge to ready high, -1 on timeout.
  task automatic xfer(input logic [15:0] a, input logic wr, input logic [31:0] d,
                      input logic [1:0] bc, input logic hold, output int lat);
    int cyc;
    logic got;
    bus.address   = {8'($urandom_range(0, 255)), a};
    bus.read      = !wr;
    bus.write     = wr;
    bus.dataIn    = d;
    bus.byteCount = bc;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 300) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (wr ? bus.dataInReady : bus.dataOutReady) got = 1'b1;
    end
    if (!hold) begin
      bus.read  = 1'b0;
      bus.write = 1'b0;
    end
    lat = got ? cyc - 1 : -1;
  endtask

  // Read transaction with scoreboard push/pop and latency check.
  task automatic read_chk(input string nm, input logic [15:0] a, input logic [1:0] bc,
                          input logic hold, input int want_lat, input logic chk_lat);
    int lat;
    logic [31:0] e;
    model_dout = model_read(a, bc, model_dout);
    exp_q.push_back(model_dout);
    xfer(a, 1'b0, 32'h0, bc, hold, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (bus.dataOut !== e) begin
      n_bad++;
      $display("FAIL %s data: got %h want %h", nm, bus.dataOut, e);
    end
    if (chk_lat) begin
      n_cmp++;
      if (lat !== want_lat) begin
        n_bad++;
        $display("FAIL %s latency: got %0d want %0d", nm, lat, want_lat);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.addressLatch0, bus.addressLatch1, bus.ramChipEnable, bus.ramRead,
         bus.ramWrite, bus.romChipEnable, bus.romRead, bus.ioOe} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset strobes: got nonzero want 0");
    end
    n_cmp++;
    if (bus.ioOut !== 8'h00 || bus.dataOut !== 32'h0) begin
      n_bad++;
      $display("FAIL reset data: got ioOut %h dataOut %h want 0", bus.ioOut, bus.dataOut);
    end
    n_cmp++;
    if ({bus.busy, bus.dataOutReady, bus.dataInReady} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset status: got %b want 000",
               {bus.busy, bus.dataOutReady, bus.dataInReady});
    end
    n_cmp++;
    if (dbg_state !== 3'd0) begin
      n_bad++;
      $display("FAIL reset state: got %0d want 0", dbg_state);
    end
    model_dout = 32'h0;
  endtask

  task automatic test_ram_read;
    ram_mem[16'h8012] = 8'hA5;
    run_q.delete();
    read_chk("ram_read_1", 16'h8012, 2'd0, 1'b0, 6, 1'b1);
    n_cmp++;
    if (bus_addr !== 16'h8012) begin
      n_bad++;
      $display("FAIL ram_read_1 latched addr: got %h want 8012", bus_addr);
    end
    n_cmp++;
    if (run_q.size() != 1 || run_q[0] != RAM_W) begin
      n_bad++;
      $display("FAIL ram_read_1 rd width: got %0d runs want one of %0d", run_q.size(), RAM_W);
    end
  endtask

  task automatic test_ram_write;
    int lat;
    logic [31:0] d;
    logic [23:0] e, o;
    d = 32'h44332211;
    run_q.delete();
    wr_obs_q.delete();
    for (int i = 0; i < 4; i++) exp_wr_q.push_back({16'h80FE + 16'(i), d[8*i +: 8]});
    xfer(16'h80FE, 1'b1, d, 2'd3, 1'b0, lat);
    n_cmp++;
    if (lat !== 21) begin
      n_bad++;
      $display("FAIL ram_write latency: got %0d want 21", lat);
    end
    n_cmp++;
    if (wr_obs_q.size() != 4) begin
      n_bad++;
      $display("FAIL ram_write count: got %0d want 4", wr_obs_q.size());
    end
    while (exp_wr_q.size() > 0) begin
      e = exp_wr_q.pop_front();
      o = (wr_obs_q.size() > 0) ? wr_obs_q.pop_front() : 24'hxxxxxx;
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL ram_write byte: got addr/data %h want %h", o, e);
      end
    end
    n_cmp++;
    if (run_q.size() != 4 || run_q[0] != RAM_W || run_q[3] != RAM_W) begin
      n_bad++;
      $display("FAIL ram_write wr width: got %0d runs want 4 of %0d", run_q.size(), RAM_W);
    end
  endtask

  task automatic test_rom_read;
    int r0;
    rom_mem[16'h0100] = 8'h3C;
    rom_mem[16'h0101] = 8'h5A;
    run_q.delete();
    r0 = ram_seen;
    read_chk("rom_read_2", 16'h0100, 2'd1, 1'b0, 13, 1'b1);
    n_cmp++;
    if (bus.dataOut[15:0] !== 16'h5A3C) begin
      n_bad++;
      $display("FAIL rom_read_2 low half: got %h want 5a3c", bus.dataOut[15:0]);
    end
    n_cmp++;
    if (ram_seen != r0) begin
      n_bad++;
      $display("FAIL rom_read_2 ram strobes: got %0d cycles want 0", ram_seen - r0);
    end
    n_cmp++;
    if (run_q.size() != 2 || run_q[0] != ROM_W || run_q[1] != ROM_W) begin
      n_bad++;
      $display("FAIL rom_read_2 rd width: got %0d runs want 2 of %0d", run_q.size(), ROM_W);
    end
  endtask

  task automatic test_rom_write;
    int lat, a0;
    a0 = act_seen;
    xfer(16'h0040, 1'b1, 32'hDEADBEEF, 2'd3, 1'b0, lat);
    n_cmp++;
    if (lat !== 1) begin
      n_bad++;
      $display("FAIL rom_write latency: got %0d want 1", lat);
    end
    n_cmp++;
    if (act_seen != a0) begin
      n_bad++;
      $display("FAIL rom_write bus activity: got %0d cycles want 0", act_seen - a0);
    end
  endtask

  task automatic test_reset_mid;
    int cyc, r0;
    bus.address   = 24'h008200;
    bus.read      = 1'b1;
    bus.write     = 1'b0;
    bus.byteCount = 2'd2;
    cyc = 0;
    while (!bus.ramRead && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (bus.ramRead !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid access: got no RD within %0d cycles want RD", cyc);
    end
    r0 = rdy_seen;
    rst = 1'b1;
    @(negedge clk);
    bus.read = 1'b0;
    n_cmp++;
    if ({bus.addressLatch0, bus.addressLatch1, bus.ramChipEnable, bus.ramRead,
         bus.ramWrite, bus.romChipEnable, bus.romRead, bus.ioOe, bus.busy} !== 9'h0) begin
      n_bad++;
      $display("FAIL reset_mid strobes: got nonzero want 0");
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_dout = 32'h0;
    repeat (8) @(negedge clk);
    n_cmp++;
    if (rdy_seen != r0) begin
      n_bad++;
      $display("FAIL reset_mid ready: got %0d pulses want 0", rdy_seen - r0);
    end
    read_chk("reset_mid_after", 16'h8300, 2'd0, 1'b0, 6, 1'b1);
  endtask

  task automatic test_back_to_back;
    int l1, l2;
`ifdef BUS_HILATCH_CACHE_EN
    l1 = 18;
    l2 = 17;
`else
    l1 = 21;
    l2 = 21;
`endif
    read_chk("b2b_first", 16'h8010, 2'd3, 1'b1, l1, 1'b1);
    read_chk("b2b_second", 16'h8010, 2'd3, 1'b0, l2, 1'b1);
  endtask

  task automatic test_random;
    logic [15:0] a;
    logic [1:0]  bc;
    logic        chk;
`ifdef BUS_HILATCH_CACHE_EN
    chk = 1'b0;
`else
    chk = 1'b1;
`endif
    // Wrap case: RAM target must hold for bytes at 0x0000/0x0001.
    read_chk("wrap_ram", 16'hFFFE, 2'd3, 1'b0, exp_lat(16'hFFFE, 2'd3), chk);
    for (int k = 0; k < 8; k++) begin
      a  = 16'($urandom_range(0, 65535));
      bc = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      read_chk("rand_read", a, bc, 1'b0, exp_lat(a, bc), chk);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram_mem[i] = 8'($urandom);
      rom_mem[i] = 8'($urandom);
    end
    bus.address   = '0;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.dataIn    = '0;
    bus.byteCount = '0;
    @(negedge clk);
    test_reset();
    test_ram_read();
    test_ram_write();
    test_rom_read();
    test_rom_write();
    test_reset_mid();
    test_back_to_back();
    test_random();
    n_cmp++;
    if (viol != 0) begin
      n_bad++;
      $display("FAIL pin invariants: got %0d violations want 0", viol);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
